// File: rtl/data_mem_pkg.sv
// Shared types and encodings for the wait-state data memory.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  // Wide enough for the largest supported wait-state count (15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dm_byte_array.sv
// Byte-lane addressable storage: per-lane synchronous write, asynchronous read.
module dm_byte_array #(
  parameter int unsigned BYTES = 2,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic               clk,
  input  logic [BYTES-1:0]   we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [8*BYTES-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [8*BYTES-1:0] rdata_c_o
);

  // Contents start at zero and are deliberately outside the reset domain.
  logic [8*BYTES-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BYTES); b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_ws.sv
// Data memory with req/ready handshake, programmable wait states, byte-lane
// stores and access-fault reporting.
module data_mem_ws
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              fault_o,
  output logic              busy_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               ready_q, ready_d, fault_q, fault_d, busy_q, busy_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               accept_c, fault_c, enter_done_c;
  logic               acc_we, acc_size;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [IDX_W-1:0]   idx_c;
  logic [OFF_W-1:0]   lane_c;
  logic [BYTES-1:0]   lane_we_c;
  logic [DATA_W-1:0]  wr_data_c, rd_word_c;

  assign accept_c = (state_q == IDLE) && req_i;

  // Live inputs on the accept edge (WAIT_CYCLES=0 completes there), latched copy later.
  always_comb begin
    acc_we    = we_q;
    acc_size  = size_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_we    = we_i;
      acc_size  = size_i;
      acc_addr  = addr_i;
      acc_wdata = wdata_i;
    end
  end

  assign idx_c   = acc_addr[ADDR_W-1:OFF_W];
  assign lane_c  = acc_addr[OFF_W-1:0];
  assign fault_c = (64'(idx_c) >= 64'(DEPTH)) ||
                   ((acc_size == SZ_WORD) && (lane_c != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Faulting accesses skip the wait states entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (fault_c || (WAIT_CYCLES == 0)) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enter_done_c = (state_d == DONE);
    lane_we_c    = '0;
    wr_data_c    = (acc_size == SZ_WORD) ? acc_wdata : {BYTES{acc_wdata[7:0]}};
    ready_d      = enter_done_c;
    fault_d      = enter_done_c && fault_c;
    busy_d       = (state_d != IDLE);
    rdata_d      = rdata_q;
    if (enter_done_c) begin
      if (fault_c) begin
        rdata_d = '0;
      end else if (acc_we) begin
        lane_we_c = (acc_size == SZ_WORD) ? {BYTES{1'b1}} : (BYTES'(1) << lane_c);
      end else begin
        rdata_d = (acc_size == SZ_WORD) ? rd_word_c
                                        : DATA_W'(8'(rd_word_c >> {lane_c, 3'b000}));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      we_q    <= we_i;
      size_q  <= size_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= ready_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  dm_byte_array #(
    .BYTES (BYTES),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .we_i      (lane_we_c),
    .waddr_i   (AW'(idx_c)),
    .wdata_i   (wr_data_c),
    .raddr_i   (AW'(idx_c)),
    .rdata_c_o (rd_word_c)
  );

  assign ready_o = ready_q;
  assign fault_o = fault_q;
  assign busy_o  = busy_q;
  assign rdata_o = rdata_q;

endmodule

// File: doc/data_mem_ws.md
# data_mem_ws

Parametrised data memory for the MIPS datapath with a request/ready handshake, configurable wait states, byte-lane writes and access-fault reporting. It replaces the fixed 16-bit × 32-word, zero-latency data memory. It sits behind the MEM stage, and the core stalls while `busy` is high. Storage width, depth and latency are set at elaboration so that the same block models slow external RAM and wider datapaths.

## Interface
- `DATA_W`, 16: word width in bits; a multiple of 8, with at least 16 bits.
- `ADDR_W`, 16: byte-address width.
- `DEPTH`, 32: number of words.
- `WAIT_CYCLES`, 2: extra cycles between accept and completion, range 0..15.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  1: access request; sampled only in IDLE.
- `we`  in  1: 1 = store, 0 = load.
- `size`  in  1: 0 = byte, 1 = full word.
- `addr`  in  ADDR_W: byte address.
- `wdata`  in  DATA_W: store data; a byte store uses `wdata[7:0]`.
- `ready`  out  1: one-cycle completion pulse.
- `rdata`  out  DATA_W: load result, held until the next completion.
- `fault`  out  1: qualifies `ready`; the access was rejected.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- `BYTES = DATA_W/8` and `OFF_W = clog2(BYTES)`.
- Word index is `addr[ADDR_W-1:OFF_W]`; byte lane is `addr[OFF_W-1:0]`.
- FSM has three states: IDLE, WAIT and DONE.
  - IDLE with `req=1`: latch `we`, `size`, `addr` and `wdata`, then go to WAIT. If `WAIT_CYCLES=0`, go straight to DONE.
  - WAIT: a counter loads `WAIT_CYCLES-1` on accept and decrements each cycle. Go to DONE when the counter reaches 0.
  - DONE: lasts one cycle, then returns to IDLE unconditionally.
- Fault check happens at accept time. A fault occurs when the word index is ≥ `DEPTH`, or when `size=1` and the byte lane is non-zero. A faulting access goes directly to DONE regardless of `WAIT_CYCLES`.
  - The completion pulse has `fault=1` and `rdata=0`.
  - Memory is not written.
- Writes commit on the clock edge that enters DONE.
  - A word store writes all lanes.
  - A byte store writes only the addressed lane.
- Load results are registered on the same edge that enters DONE.
  - A word load returns the whole word.
  - A byte load returns the addressed lane zero-extended into `rdata[7:0]`. Sign extension is the core's job.
- `req` is ignored in WAIT and DONE. Inputs need not be held after accept.
- Memory contents initialise to all-zero at time 0 and are not affected by `rst_n`.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `ready=0`, `fault=0`, `rdata=0`, `busy=0`.
- Accept happens at edge k. `ready` is high in cycle k+1+`WAIT_CYCLES`, or in cycle k+1 for a fault.
- `busy` rises in the cycle after accept and falls in the cycle after `ready`.
- Maximum throughput is one access per `WAIT_CYCLES+2` cycles. A `req` held high through DONE is accepted on the first IDLE edge.
- Read-after-write: a load that follows a store to the same word returns the stored value.
- `rst_n` asserted mid-access:
  - the access is dropped;
  - a store that has not yet reached DONE never writes;
  - no `ready` pulse is produced.
- `fault` is 0 whenever `ready` is 0.

## Structure
- Shared package `data_mem_pkg` holds:
  - the state enum (IDLE/WAIT/DONE);
  - size encodings `SZ_BYTE=0` and `SZ_WORD=1`.
- Sub-module `dm_byte_array` provides `DEPTH × BYTES` storage with:
  - a per-lane write enable on `clk`;
  - an asynchronous read port;
  - zero initialisation.
- The top level holds the FSM, wait counter, fault logic, lane select and output registers.

## Test plan
All scenarios use the default parameters.
- **Reset:** drive `rst_n=0` mid-WAIT of a store of 0xBEEF to address 0x0004, then load 0x0004 → `ready` never pulses for the store; the load returns 0x0000.
- **Word round trip:** store 0x1234 at address 0x0006, then load 0x0006 → `ready` is high exactly 3 cycles after each accept; `rdata=0x1234`; `busy` is high for 3 cycles.
- **Byte lanes:** store word 0xAAAA at address 0x0010, store byte 0x55 at address 0x0011, load word at 0x0010 → 0x55AA. A byte load at 0x0011 → 0x0055.
- **Faults:**
  - word load at address 0x0003 → `ready`=`fault`=1 one cycle after accept, `rdata=0`;
  - store to address 0x0040 (index 32) → fault, and the array is unchanged.
- **Handshake:** hold `req=1` continuously with alternating load/store → exactly one accept every 4 cycles; no accept while `busy=1`.
- **`WAIT_CYCLES=0`, `DATA_W=32`:** store 0xDEADBEEF at address 0x0008 and load it back → `ready` one cycle after each accept, `rdata=0xDEADBEEF`.
